// File: rtl/seq_divider16by8_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and
// default operand widths.
package div_pkg;

  localparam int N_DEF = 16;
  localparam int D_DEF = 8;
  localparam int CNT_W = $clog2(N_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider16by8_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step #(
  parameter int D = 8
) (
  input  logic [D:0]   r,
  input  logic         q_msb,
  input  logic [D-1:0] dv,
  output logic [D:0]   r_next,
  output logic         q_bit
);

  logic [D:0] r_sh;
  logic [D:0] t;

  always_comb begin
    r_sh = {r[D-1:0], q_msb};
    t    = r_sh - {1'b0, dv};
    // r stays below dv, so r[D] is always clear; were it set, the shifted
    // value would exceed any divisor and the subtract must be taken.
    q_bit  = r[D] | ~t[D];
    r_next = q_bit ? {1'b0, t[D-1:0]} : r_sh;
  end

endmodule

// File: rtl/seq_divider16by8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and divide-by-zero flag.
module seq_divider16by8
  import div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t         state;
  logic [N-1:0]   q_sh;
  logic [D-1:0]   dv;
  logic [D:0]     rem;
  logic [CW-1:0]  cnt;
  logic [D:0]     r_next;
  logic           q_bit;
  logic [N-1:0]   q_next;

  div_step #(.D(D)) u_step (
    .r      (rem),
    .q_msb  (q_sh[N-1]),
    .dv     (dv),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_sh[N-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_sh        <= '0;
      dv          <= '0;
      rem         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            q_sh        <= dividend;
            dv          <= divisor;
            rem         <= '0;
            cnt         <= CW'(N);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor resolves immediately; no iterations are run.
              state       <= ST_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[D-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          q_sh <= q_next;
          rem  <= r_next;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[D-1:0];
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
